// File: rtl/param_stack.sv
// Parametrised LIFO with full/empty, occupancy, sticky error flags and pipeline pop qualifiers.
// Optional error interrupt pulse is built when PARAM_STACK_IRQ_EN is defined.
module param_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic             hold_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             err_clr_i,
  output logic             irq_o
);

  localparam logic [AW:0] CntOne  = (AW+1)'(1);
  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // The pointer always equals the occupancy, so count doubles as the next-free address.
  logic [AW:0]      count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] q_hold_q, q_hold_d;
  logic [WIDTH-1:0] rd_data_q;

  logic             eff_pop, pop_ok, do_push, replace;
  logic             ov_set, un_set, q_zero;
  logic             we, re;
  logic [AW-1:0]    top_addr, wr_addr;

  always_comb begin
    eff_pop  = pop_i & ~clear_i & ~hold_i;
    pop_ok   = eff_pop & ~empty_q;
    replace  = push_i & pop_ok;
    do_push  = push_i & ~pop_ok & ~full_q;
    ov_set   = push_i & ~pop_ok & full_q;
    un_set   = eff_pop & empty_q;
    q_zero   = (pop_i & clear_i) | un_set;
    top_addr = AW'(count_q - CntOne);
    we       = do_push | replace;
    re       = pop_ok;
    wr_addr  = replace ? top_addr : count_q[AW-1:0];

    count_d = count_q;
    if (pop_ok && !push_i) begin
      count_d = count_q - CntOne;
    end else if (do_push) begin
      count_d = count_q + CntOne;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CntFull);

    overflow_d  = ov_set | (overflow_q & ~err_clr_i);
    underflow_d = un_set | (underflow_q & ~err_clr_i);

    rd_valid_d = pop_ok;
    q_hold_d   = q_zero ? '0 : q_o;
  end

  // Read-first RAM: a write from an earlier cycle is visible to the next read, and a
  // same-cycle replace returns the old top as required.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= d_i;
    end
    if (re) begin
      rd_data_q <= mem[top_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      q_hold_q    <= '0;
    end else begin
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      q_hold_q    <= q_hold_d;
    end
  end

  assign q_o         = rd_valid_q ? rd_data_q : q_hold_q;
  assign count_o     = count_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

`ifdef PARAM_STACK_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (overflow_d & ~overflow_q) | (underflow_d & ~underflow_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: directed scenarios plus random traffic against a
// queue-based stack model.
module tb_param_stack;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [Width-1:0]  d_i;
  logic [Width-1:0]  q_o;
  logic              push_i, pop_i, clear_i, hold_i, err_clr_i;
  logic              empty_o, full_o, overflow_o, underflow_o, irq_o;
  logic [2:0]        count_o;

  param_stack #(
    .WIDTH(Width),
    .DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_i        (d_i),
    .q_o        (q_o),
    .push_i     (push_i),
    .pop_i      (pop_i),
    .clear_i    (clear_i),
    .hold_i     (hold_i),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o),
    .err_clr_i  (err_clr_i),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [2:0]  cnt;
    logic        e, f, ov, un, irq;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] stk[$];
  logic [31:0] m_q;
  logic        m_ov, m_un, m_irq;
  int          total = 0;
  int          bad = 0;

`ifdef PARAM_STACK_IRQ_EN
  localparam bit IrqBuild = 1'b1;
`else
  localparam bit IrqBuild = 1'b0;
`endif

  task automatic step(input logic rs, input logic ps, input logic pp, input logic cl,
                      input logic hd, input logic ec, input logic [31:0] dv);
    logic ov_new, un_new, old_ov, old_un;
    exp_t e;
    @(negedge clk);
    reset = rs; push_i = ps; pop_i = pp; clear_i = cl; hold_i = hd; err_clr_i = ec; d_i = dv;
    if (rs) begin
      stk.delete();
      m_q = '0; m_ov = 1'b0; m_un = 1'b0; m_irq = 1'b0;
    end else begin
      ov_new = 1'b0; un_new = 1'b0;
      old_ov = m_ov; old_un = m_un;
      if (pp && cl) begin
        m_q = '0;
        if (ps) begin
          if (stk.size() < Depth) stk.push_back(dv); else ov_new = 1'b1;
        end
      end else if (pp && !hd) begin
        if (stk.size() > 0) begin
          m_q = stk[stk.size()-1];
          if (ps) stk[stk.size()-1] = dv; else void'(stk.pop_back());
        end else begin
          m_q = '0;
          un_new = 1'b1;
          if (ps) stk.push_back(dv);
        end
      end else if (ps) begin
        if (stk.size() < Depth) stk.push_back(dv); else ov_new = 1'b1;
      end
      m_ov  = ov_new | (m_ov & !ec);
      m_un  = un_new | (m_un & !ec);
      m_irq = IrqBuild && ((m_ov && !old_ov) || (m_un && !old_un));
    end
    e.q   = m_q;
    e.cnt = 3'(stk.size());
    e.e   = (stk.size() == 0);
    e.f   = (stk.size() == Depth);
    e.ov  = m_ov;
    e.un  = m_un;
    e.irq = m_irq;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every clocked cycle presents a full output set to compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("q", q_o, e.q);
      chk("count", 32'(count_o), 32'(e.cnt));
      chk("empty", 32'(empty_o), 32'(e.e));
      chk("full", 32'(full_o), 32'(e.f));
      chk("overflow", 32'(overflow_o), 32'(e.ov));
      chk("underflow", 32'(underflow_o), 32'(e.un));
      chk("irq", 32'(irq_o), 32'(e.irq));
    end
  end

  initial begin
    reset = 1'b1; push_i = 0; pop_i = 0; clear_i = 0; hold_i = 0; err_clr_i = 0; d_i = '0;
    m_q = '0; m_ov = 0; m_un = 0; m_irq = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // LIFO order
    step(0, 1, 0, 0, 0, 0, 32'h11);
    step(0, 1, 0, 0, 0, 0, 32'h22);
    step(0, 1, 0, 0, 0, 0, 32'h33);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    idle();
    // Overflow, then pop returns the 4th value; repeat overflow for single irq
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 32'h100 + i);
    step(0, 1, 0, 0, 0, 0, 32'hDEAD);
    step(0, 1, 0, 0, 0, 0, 32'hDEAD);
    idle();
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 32'hBEEF);
    step(0, 1, 1, 0, 0, 0, 32'h777);
    step(0, 0, 1, 0, 0, 0, 0);
    idle();
    // Underflow from reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    // Replace top
    step(0, 1, 0, 0, 0, 0, 32'hA);
    step(0, 1, 0, 0, 0, 0, 32'hB);
    step(0, 1, 1, 0, 0, 0, 32'hC);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    // Hold and clear qualifiers
    step(0, 1, 0, 0, 0, 0, 32'h5);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 32'h9);
    idle();
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0), $urandom);
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
